// File: rtl/bw_clk_cl_jbus_seq_if.sv
// Request/status bundle between the clock/reset controller and one jbus
// cluster-header sequencer; master issues requests, slave drives header levels.
interface bw_clk_cl_jbus_seq_if;
  logic start;
  logic stop;
  logic dbg_req;
  logic cluster_cken;
  logic grst_l;
  logic gdbginit_l;
  logic ready;
  logic busy;

  modport master (
    output start, stop, dbg_req,
    input  cluster_cken, grst_l, gdbginit_l, ready, busy
  );

  modport slave (
    input  start, stop, dbg_req,
    output cluster_cken, grst_l, gdbginit_l, ready, busy
  );
endinterface

// File: rtl/bw_clk_cl_jbus_seq.sv
// Power-up/down sequencer for a jbus cluster clock header: clock on, reset release, run, debug-init, halt.
// All outputs registered; requests are level-sampled, no backpressure -- requests outside their state are dropped.
module bw_clk_cl_jbus_seq #(
  parameter int CNT_W    = 8,
  parameter int CKEN_DLY = 16,
  parameter int RST_DLY  = 8,
  parameter int DBG_LEN  = 4,
  parameter int HALT_DLY = 8
) (
  input  logic                    gclk,
  input  logic                    arst_l,
  bw_clk_cl_jbus_seq_if.slave     bus
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_CKEN = 3'd1,
    S_RSTW = 3'd2,
    S_RUN  = 3'd3,
    S_DBG  = 3'd4,
    S_HALT = 3'd5
  } state_t;

  // Counters load N-1 so that a phase lasts exactly N cycles including the cnt==0 cycle.
  localparam logic [CNT_W-1:0] CKEN_LD = CNT_W'(CKEN_DLY - 1);
  localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_DLY - 1);
  localparam logic [CNT_W-1:0] DBG_LD  = CNT_W'(DBG_LEN - 1);
  localparam logic [CNT_W-1:0] HALT_LD = CNT_W'(HALT_DLY - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             stop_pend;
  logic             cken_q;
  logic             grst_q;
  logic             dbg_q;
  logic             ready_q;
  logic             busy_q;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      state     <= S_OFF;
      cnt       <= '0;
      stop_pend <= 1'b0;
      cken_q    <= 1'b0;
      grst_q    <= 1'b0;
      dbg_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        S_OFF: begin
          if (bus.start) begin
            state  <= S_CKEN;
            cnt    <= CKEN_LD;
            cken_q <= 1'b1;
            busy_q <= 1'b1;
          end
        end

        S_CKEN: begin
          if (cnt_zero) begin
            state  <= S_RSTW;
            cnt    <= RST_LD;
            grst_q <= 1'b1;
            dbg_q  <= 1'b1;
          end else begin
            cnt <= cnt - ONE;
          end
        end

        S_RSTW: begin
          if (cnt_zero) begin
            state   <= S_RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt - ONE;
          end
        end

        // stop wins over a coincident dbg_req; the debug request is dropped.
        S_RUN: begin
          if (bus.stop) begin
            state   <= S_HALT;
            cnt     <= HALT_LD;
            grst_q  <= 1'b0;
            dbg_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else if (bus.dbg_req) begin
            state   <= S_DBG;
            cnt     <= DBG_LD;
            dbg_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        // A stop seen anywhere in the pulse is held until the pulse completes.
        S_DBG: begin
          if (cnt_zero) begin
            stop_pend <= 1'b0;
            if (stop_pend || bus.stop) begin
              state   <= S_HALT;
              cnt     <= HALT_LD;
              grst_q  <= 1'b0;
              dbg_q   <= 1'b0;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              state   <= S_RUN;
              dbg_q   <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt <= cnt - ONE;
            if (bus.stop) begin
              stop_pend <= 1'b1;
            end
          end
        end

        S_HALT: begin
          if (cnt_zero) begin
            state  <= S_OFF;
            cken_q <= 1'b0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - ONE;
          end
        end

        default: begin
          state     <= S_OFF;
          cnt       <= '0;
          stop_pend <= 1'b0;
          cken_q    <= 1'b0;
          grst_q    <= 1'b0;
          dbg_q     <= 1'b0;
          ready_q   <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cluster_cken = cken_q;
  assign bus.grst_l       = grst_q;
  assign bus.gdbginit_l   = dbg_q;
  assign bus.ready        = ready_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_bw_clk_cl_jbus_seq.sv
// Directed bench for the jbus cluster sequencer: stimulus queues expected output
// changes {cycle, levels}; a monitor pops one per observed output change.
module tb_bw_clk_cl_jbus_seq;

  logic gclk   = 1'b0;
  logic arst_l = 1'b0;
  int   cyc    = 0;
  bit   stim_done = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  bw_clk_cl_jbus_seq_if bus();

  bw_clk_cl_jbus_seq dut (
    .gclk   (gclk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;

  // Output vector order: {cluster_cken, grst_l, gdbginit_l, ready, busy}
  localparam logic [4:0] O_OFF  = 5'b00000;
  localparam logic [4:0] O_CKEN = 5'b10001;
  localparam logic [4:0] O_RSTW = 5'b11101;
  localparam logic [4:0] O_RUN  = 5'b11110;
  localparam logic [4:0] O_DBG  = 5'b11001;
  localparam logic [4:0] O_HALT = 5'b10001;

  logic [4:0] outs;
  assign outs = {bus.cluster_cken, bus.grst_l, bus.gdbginit_l, bus.ready, bus.busy};

  typedef struct {
    int         cyc;
    logic [4:0] o;
  } ev_t;

  ev_t exp_q[$];

  task automatic expect_ev(input int c, input logic [4:0] o);
    ev_t e;
    e.cyc = c;
    e.o   = o;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge gclk);
  endtask

  task automatic powerup();
    int c;
    c = cyc;
    bus.start = 1'b1;
    expect_ev(c + 1,  O_CKEN);
    expect_ev(c + 17, O_RSTW);
    expect_ev(c + 25, O_RUN);
    @(negedge gclk);
    bus.start = 1'b0;
    wait_to(c + 27);
  endtask

  task automatic stop_now();
    int c;
    c = cyc;
    bus.stop = 1'b1;
    expect_ev(c + 1, O_HALT);
    expect_ev(c + 9, O_OFF);
    @(negedge gclk);
    bus.stop = 1'b0;
    wait_to(c + 11);
  endtask

  // Stimulus
  initial begin
    int c;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.dbg_req = 1'b0;
    repeat (3) @(negedge gclk);
    arst_l = 1'b1;
    repeat (2) @(negedge gclk);

    // Power-up: cken at +1, reset release at +17, ready at +25
    powerup();

    // Single debug-init pulse: gdbginit_l/ready low for 4 cycles
    c = cyc;
    bus.dbg_req = 1'b1;
    expect_ev(c + 1, O_DBG);
    expect_ev(c + 5, O_RUN);
    @(negedge gclk);
    bus.dbg_req = 1'b0;
    wait_to(c + 8);

    // Stop in 2nd debug cycle: pulse completes, then 8-cycle halt, then off
    c = cyc;
    bus.dbg_req = 1'b1;
    expect_ev(c + 1,  O_DBG);
    expect_ev(c + 5,  O_HALT);
    expect_ev(c + 13, O_OFF);
    @(negedge gclk);
    bus.dbg_req = 1'b0;
    wait_to(c + 2);
    bus.stop = 1'b1;
    @(negedge gclk);
    bus.stop = 1'b0;
    wait_to(c + 20);

    // Simultaneous stop and dbg_req in RUN: halt wins
    powerup();
    c = cyc;
    bus.stop    = 1'b1;
    bus.dbg_req = 1'b1;
    expect_ev(c + 1, O_HALT);
    expect_ev(c + 9, O_OFF);
    @(negedge gclk);
    bus.stop    = 1'b0;
    bus.dbg_req = 1'b0;
    wait_to(c + 12);

    // start held through RUN and HALT: restarts only once back in OFF
    c = cyc;
    bus.start = 1'b1;
    expect_ev(c + 1,  O_CKEN);
    expect_ev(c + 17, O_RSTW);
    expect_ev(c + 25, O_RUN);
    wait_to(c + 30);
    bus.stop = 1'b1;
    expect_ev(c + 31, O_HALT);
    expect_ev(c + 39, O_OFF);
    expect_ev(c + 40, O_CKEN);
    expect_ev(c + 56, O_RSTW);
    expect_ev(c + 64, O_RUN);
    @(negedge gclk);
    bus.stop = 1'b0;
    wait_to(c + 40);
    bus.start = 1'b0;
    wait_to(c + 66);
    stop_now();

    // stop and dbg_req in OFF are ignored
    c = cyc;
    bus.stop    = 1'b1;
    bus.dbg_req = 1'b1;
    wait_to(c + 3);
    bus.stop    = 1'b0;
    bus.dbg_req = 1'b0;
    wait_to(c + 5);

    // stop and dbg_req in CKEN are ignored
    c = cyc;
    bus.start = 1'b1;
    expect_ev(c + 1,  O_CKEN);
    expect_ev(c + 17, O_RSTW);
    expect_ev(c + 25, O_RUN);
    @(negedge gclk);
    bus.start = 1'b0;
    wait_to(c + 3);
    bus.stop    = 1'b1;
    bus.dbg_req = 1'b1;
    wait_to(c + 6);
    bus.stop    = 1'b0;
    bus.dbg_req = 1'b0;
    wait_to(c + 27);
    stop_now();

    // Async reset in CKEN: outputs clear before the next gclk edge
    c = cyc;
    bus.start = 1'b1;
    expect_ev(c + 1, O_CKEN);
    @(negedge gclk);
    bus.start = 1'b0;
    wait_to(c + 10);
    #2;
    expect_ev(cyc, O_OFF);
    arst_l = 1'b0;
    repeat (2) @(negedge gclk);
    arst_l = 1'b1;
    repeat (6) @(negedge gclk);

    // Async reset mid-DBG
    powerup();
    c = cyc;
    bus.dbg_req = 1'b1;
    expect_ev(c + 1, O_DBG);
    @(negedge gclk);
    bus.dbg_req = 1'b0;
    wait_to(c + 2);
    #2;
    expect_ev(cyc, O_OFF);
    arst_l = 1'b0;
    repeat (2) @(negedge gclk);
    arst_l = 1'b1;
    repeat (5) @(negedge gclk);

    // Recovery after reset
    powerup();
    stop_now();
    stim_done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    logic [4:0] prev;
    logic [4:0] cur;
    ev_t        e;
    bit         first;
    prev  = O_OFF;
    first = 1'b1;
    forever begin
      @(negedge gclk or negedge arst_l);
      #1;
      cur = outs;
      if (first) begin
        total++;
        if (cur !== O_OFF) begin
          bad++;
          $display("FAIL reset_state: got %b want %b", cur, O_OFF);
        end
        first = 1'b0;
      end
      total++;
      if ((cur[3] && !cur[4]) || (cur[2] && !cur[3]) || (cur[1] && cur[0]) || $isunknown(cur)) begin
        bad++;
        $display("FAIL invariant: cyc=%0d outputs=%b", cyc, cur);
      end
      if (cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: cyc=%0d got %b was %b, none expected", cyc, cur, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.o !== cur) begin
            bad++;
            $display("FAIL output_change: got cyc=%0d %b want cyc=%0d %b", cyc, cur, e.cyc, e.o);
          end
        end
      end
      prev = cur;
      if (stim_done) begin
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL missing_changes: %0d expected changes never seen, next at cyc=%0d want %b",
                   exp_q.size(), exp_q[0].cyc, exp_q[0].o);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
